// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender (sign / zero / sign-shift / upper-place) behind a
// valid/ready stage with a 2-entry skid buffer, synchronous flush and drop counter.
module imm_extend_pipe #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 8,
    parameter int SHIFT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_imm,
    output logic [1:0]       out_mode,
    output logic [7:0]       drop_cnt
);

    logic [OUT_W-1:0] sext, zext, ext;

    logic             main_valid, main_valid_n;
    logic [OUT_W-1:0] main_imm, main_imm_n;
    logic [1:0]       main_mode, main_mode_n;
    logic             skid_valid, skid_valid_n;
    logic [OUT_W-1:0] skid_imm, skid_imm_n;
    logic [1:0]       skid_mode, skid_mode_n;
    logic             ready_q, ready_n;
    logic [7:0]       drop_q, drop_n;

    logic             acc, drain;
    logic [1:0]       ndrop;
    logic [8:0]       drop_sum;

    always_comb begin
        sext = OUT_W'($signed(in_imm));
        zext = OUT_W'(in_imm);
        ext  = '0;
        case (in_mode)
            2'b00:   ext = sext;
            2'b01:   ext = zext;
            2'b10:   ext = sext << SHIFT;
            default: ext = zext << (OUT_W - IN_W);
        endcase
    end

    // in_ready is a registered copy of "skid will be empty", so out_ready never
    // reaches in_ready combinationally.
    always_comb begin
        main_valid_n = main_valid;
        main_imm_n   = main_imm;
        main_mode_n  = main_mode;
        skid_valid_n = skid_valid;
        skid_imm_n   = skid_imm;
        skid_mode_n  = skid_mode;
        drop_n       = drop_q;
        acc          = in_valid & ready_q & ~flush;
        drain        = main_valid & out_ready;
        ndrop        = {1'b0, main_valid & ~out_ready} + {1'b0, skid_valid};
        drop_sum     = {1'b0, drop_q} + {7'b0, ndrop};

        if (flush) begin
            main_valid_n = 1'b0;
            skid_valid_n = 1'b0;
            drop_n       = drop_sum[8] ? 8'hFF : drop_sum[7:0];
        end else if (!main_valid || drain) begin
            if (skid_valid) begin
                main_valid_n = 1'b1;
                main_imm_n   = skid_imm;
                main_mode_n  = skid_mode;
                skid_valid_n = 1'b0;
            end else if (acc) begin
                main_valid_n = 1'b1;
                main_imm_n   = ext;
                main_mode_n  = in_mode;
            end else begin
                main_valid_n = 1'b0;
            end
        end else if (acc) begin
            skid_valid_n = 1'b1;
            skid_imm_n   = ext;
            skid_mode_n  = in_mode;
        end
        ready_n = ~skid_valid_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            main_imm   <= '0;
            main_mode  <= '0;
            skid_valid <= 1'b0;
            skid_imm   <= '0;
            skid_mode  <= '0;
            ready_q    <= 1'b0;
            drop_q     <= '0;
        end else begin
            main_valid <= main_valid_n;
            main_imm   <= main_imm_n;
            main_mode  <= main_mode_n;
            skid_valid <= skid_valid_n;
            skid_imm   <= skid_imm_n;
            skid_mode  <= skid_mode_n;
            ready_q    <= ready_n;
            drop_q     <= drop_n;
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = main_valid;
    assign out_imm   = main_imm;
    assign out_mode  = main_mode;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed, table-driven bench for imm_extend_pipe (IN_W=4, OUT_W=8, SHIFT=1).
module tb_imm_extend_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_imm;
    logic [1:0] in_mode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_imm;
    logic [1:0] out_mode;
    logic [7:0] drop_cnt;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [3:0] imm;
        logic [1:0] mode;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [10];

    imm_extend_pipe #(.IN_W(4), .OUT_W(8), .SHIFT(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_imm   (out_imm),
        .out_mode  (out_mode),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [3:0] imm, input logic [1:0] mode);
        in_valid = 1'b1;
        in_imm   = imm;
        in_mode  = mode;
    endtask

    initial begin
        vecs[0] = '{4'b1010, 2'b00, 8'hFA};
        vecs[1] = '{4'b1010, 2'b01, 8'h0A};
        vecs[2] = '{4'b1010, 2'b10, 8'hF4};
        vecs[3] = '{4'b1010, 2'b11, 8'hA0};
        vecs[4] = '{4'b0111, 2'b00, 8'h07};
        vecs[5] = '{4'b0111, 2'b10, 8'h0E};
        vecs[6] = '{4'b0111, 2'b01, 8'h07};
        vecs[7] = '{4'b0111, 2'b11, 8'h70};
        vecs[8] = '{4'b1000, 2'b10, 8'hF0};
        vecs[9] = '{4'b1111, 2'b00, 8'hFF};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_imm = '0; in_mode = '0; out_ready = 1'b1;
        #12;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_imm",   32'(out_imm),   32'd0);
        check("reset_out_mode",  32'(out_mode),  32'd0);
        check("reset_drop_cnt",  32'(drop_cnt),  32'd0);
        rst_n = 1'b1;
        step();
        check("reset_in_ready", 32'(in_ready), 32'd1);

        // Back-to-back vectors with out_ready=1: each result one cycle after accept.
        for (int i = 0; i < 10; i++) begin
            offer(vecs[i].imm, vecs[i].mode);
            step();
            check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("vec%0d_imm", i),   32'(out_imm),   32'(vecs[i].exp));
            check($sformatf("vec%0d_mode", i),  32'(out_mode),  32'(vecs[i].mode));
        end
        in_valid = 1'b0;
        step();
        check("idle_out_valid", 32'(out_valid), 32'd0);

        // Backpressure: three inputs against a stalled output.
        out_ready = 1'b0;
        offer(4'd1, 2'b00);
        step();
        check("bp_first_valid", 32'(out_valid), 32'd1);
        check("bp_first_imm",   32'(out_imm),   32'h01);
        check("bp_ready_1",     32'(in_ready),  32'd1);
        offer(4'd2, 2'b00);
        step();
        check("bp_ready_2", 32'(in_ready), 32'd0);
        offer(4'd3, 2'b00);
        step();
        check("bp_hold_ready", 32'(in_ready), 32'd0);
        check("bp_hold_imm",   32'(out_imm),  32'h01);
        out_ready = 1'b1;
        step();
        check("bp_out2_imm",  32'(out_imm),  32'h02);
        check("bp_ready_ret", 32'(in_ready), 32'd1);
        step();
        check("bp_out3_valid", 32'(out_valid), 32'd1);
        check("bp_out3_imm",   32'(out_imm),   32'h03);
        in_valid = 1'b0;
        step();
        check("bp_drained", 32'(out_valid), 32'd0);

        // Flush with both entries buffered.
        out_ready = 1'b0;
        offer(4'd4, 2'b00);
        step();
        offer(4'd5, 2'b00);
        step();
        check("fl2_full", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("fl2_out_valid", 32'(out_valid), 32'd0);
        check("fl2_drop",      32'(drop_cnt),  32'd2);
        check("fl2_in_ready",  32'(in_ready),  32'd1);

        // Flush with one entry while a new input is offered: that input is discarded.
        offer(4'd7, 2'b00);
        step();
        offer(4'd9, 2'b00);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl1_out_valid", 32'(out_valid), 32'd0);
        check("fl1_drop",      32'(drop_cnt),  32'd3);
        step();
        check("fl1_no_leak", 32'(out_valid), 32'd0);

        // Flush coinciding with an output transfer: delivered, not counted.
        offer(4'd5, 2'b01);
        step();
        in_valid = 1'b0;
        out_ready = 1'b1;
        flush = 1'b1;
        check("flx_deliver_valid", 32'(out_valid), 32'd1);
        check("flx_deliver_imm",   32'(out_imm),   32'h05);
        step();
        flush = 1'b0;
        check("flx_drop",      32'(drop_cnt),  32'd3);
        check("flx_out_valid", 32'(out_valid), 32'd0);

        // Asynchronous reset with the skid full.
        out_ready = 1'b0;
        offer(4'd1, 2'b00);
        step();
        offer(4'd2, 2'b00);
        step();
        check("rst_skid_full", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_valid", 32'(out_valid), 32'd0);
        check("rst_async_imm",   32'(out_imm),   32'd0);
        check("rst_async_drop",  32'(drop_cnt),  32'd0);
        #3;
        rst_n = 1'b1;
        step();
        check("rst_rel_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        offer(4'b1000, 2'b00);
        step();
        in_valid = 1'b0;
        check("rst_new_valid", 32'(out_valid), 32'd1);
        check("rst_new_imm",   32'(out_imm),   32'hF8);
        step();
        check("rst_new_drained", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
